sbasu3_top: RTL and testbench

- SPI-slave-controlled multi-channel 8-bit PWM generator behind an 8-bit packed I/O interface (io_in/io_out).
- An external SPI master writes and reads per-channel period/duty registers through 3-byte transactions.
- The block drives up to 7 PWM outputs plus MISO, all in the single sys_clk domain.

---
 rtl/sbasu3_top.sv | 199 +++++++++++++++++++
 tb/tb_sbasu3_top.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sbasu3_top.sv
// SPI-slave-controlled multi-channel 8-bit PWM generator on a packed 8-bit I/O port.
// Define PWM_PRESCALER_EN to divide the PWM tick by 2^PRESCALE_LOG2 sys_clk cycles.

module sbasu3_pwm_ch (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       wr,
    input  logic [7:0] wr_period,
    input  logic [7:0] wr_duty,
    output logic [7:0] period,
    output logic [7:0] duty,
    output logic       pwm
);
    logic [7:0] cnt;
    logic [8:0] cnt_inc;

    assign cnt_inc = {1'b0, cnt} + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period <= '0;
            duty   <= '0;
            cnt    <= '0;
            pwm    <= 1'b0;
        end else begin
            if (wr) begin
                period <= wr_period;
                duty   <= wr_duty;
                cnt    <= '0;
            end else if (tick) begin
                cnt <= (cnt_inc >= {1'b0, period}) ? 8'd0 : cnt_inc[7:0];
            end
            // A zero period parks the output low regardless of duty
            pwm <= (period != 8'd0) && (cnt < duty);
        end
    end
endmodule

module sbasu3_top #(
    parameter int NUM_PWM       = 4,
    parameter int PRESCALE_LOG2 = 3
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    typedef enum logic [1:0] {ST_CMD, ST_D0, ST_D1} state_t;

    logic clk, rst_n;
    assign clk   = io_in[0];
    assign rst_n = io_in[1];

    logic unused_io;
    assign unused_io = ^io_in[7:5];

    logic [2:0] ss_sync, sclk_sync;
    logic [1:0] mosi_sync;
    logic       ss_s, ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
        end else begin
            ss_sync   <= {ss_sync[1:0], io_in[2]};
            sclk_sync <= {sclk_sync[1:0], io_in[3]};
            mosi_sync <= {mosi_sync[0], io_in[4]};
        end
    end

    assign ss_s      = ss_sync[1];
    assign ss_rise   = ss_sync[1] & ~ss_sync[2];
    assign ss_fall   = ~ss_sync[1] & ss_sync[2];
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign mosi_s    = mosi_sync[1];

    logic                            tick;
    logic [3:0]                      bit_cnt;
    logic [7:0]                      rx, tx, tx_next, shadow, rd_period, rd_duty;
    logic [2:0]                      addr_q, rd_addr;
    logic                            rnw, byte_done, latch_cmd, wr_shadow, commit;
    state_t                          state, state_nxt;
    logic [NUM_PWM-1:0]              ch_wr, pwm_vec;
    logic [NUM_PWM-1:0][7:0]         period, duty;

`ifdef PWM_PRESCALER_EN
    logic [PRESCALE_LOG2-1:0] div;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div <= '0;
        else        div <= div + PRESCALE_LOG2'(1);
    end
    assign tick = &div;
`else
    localparam int unused_ps = PRESCALE_LOG2;
    assign tick = 1'b1;
`endif

    // Bytes are acted on at ss fall, after the 8th sclk fall, so a freshly
    // loaded tx keeps its MSB on miso for the next byte.
    assign byte_done = ss_fall && (bit_cnt == 4'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            rx      <= '0;
            tx      <= '0;
        end else begin
            if (ss_rise)
                bit_cnt <= '0;
            else if (ss_s && sclk_rise && bit_cnt != 4'd8) begin
                rx      <= {rx[6:0], mosi_s};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (byte_done)
                tx <= tx_next;
            else if (ss_s && sclk_fall)
                tx <= {tx[6:0], 1'b0};
        end
    end

    assign rd_addr = (state == ST_CMD) ? rx[2:0] : addr_q;

    always_comb begin
        rd_period = '0;
        rd_duty   = '0;
        for (int k = 0; k < NUM_PWM; k++) begin
            if (rd_addr == 3'(k)) begin
                rd_period = period[k];
                rd_duty   = duty[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_CMD;
            rnw    <= 1'b0;
            addr_q <= '0;
            shadow <= '0;
        end else begin
            state <= state_nxt;
            if (latch_cmd) begin
                rnw    <= rx[7];
                addr_q <= rx[2:0];
            end
            if (wr_shadow) shadow <= rx;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_next   = 8'h00;
        latch_cmd = 1'b0;
        wr_shadow = 1'b0;
        commit    = 1'b0;
        if (byte_done) begin
            case (state)
                ST_CMD: begin
                    latch_cmd = 1'b1;
                    tx_next   = rx[7] ? rd_period : 8'h00;
                    state_nxt = ST_D0;
                end
                ST_D0: begin
                    wr_shadow = !rnw;
                    tx_next   = rnw ? rd_duty : 8'h00;
                    state_nxt = ST_D1;
                end
                ST_D1: begin
                    commit    = !rnw;
                    state_nxt = ST_CMD;
                end
                default: state_nxt = ST_CMD;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PWM; g++) begin : g_ch
        assign ch_wr[g] = commit && (addr_q == 3'(g));
        sbasu3_pwm_ch u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .wr        (ch_wr[g]),
            .wr_period (shadow),
            .wr_duty   (rx),
            .period    (period[g]),
            .duty      (duty[g]),
            .pwm       (pwm_vec[g])
        );
    end

    always_comb begin
        io_out            = '0;
        io_out[0]         = tx[7];
        io_out[NUM_PWM:1] = pwm_vec;
    end
endmodule

// File: tb/tb_sbasu3_top.sv
// Directed + randomized bench for sbasu3_top: SPI register access and PWM waveforms
// checked against an array model of the channel registers and an arithmetic waveform model.

module tb_sbasu3_top;
    localparam int NUM_PWM = 4;
`ifdef PWM_PRESCALER_EN
    localparam int SCALE = 8;
`else
    localparam int SCALE = 1;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, ss = 1'b0, sclk = 1'b0, mosi = 1'b0;
    logic [2:0] junk = 3'd0;
    logic [7:0] io_in, io_out;

    assign io_in = {junk, mosi, sclk, ss, rst_n, clk};

    sbasu3_top #(.NUM_PWM(NUM_PWM), .PRESCALE_LOG2(3)) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int mper[8];
    int mduty[8];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One ss-framed byte, mode 0; miso is sampled just before each sclk rise.
    task automatic spi_byte(input logic [7:0] din, input int nbits, output logic [7:0] dout);
        dout = 8'h00;
        junk = 3'($urandom);
        ss = 1'b1;
        wait_clks(4);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 8) ? din[7-i] : 1'b0;
            wait_clks(4);
            dout = {dout[6:0], io_out[0]};
            sclk = 1'b1;
            wait_clks(4);
            sclk = 1'b0;
        end
        wait_clks(4);
        ss = 1'b0;
        wait_clks(4);
    endtask

    task automatic spi_write(input int a, input int p, input int d);
        logic [7:0] b, cmd;
        logic [3:0] j;
        j = 4'($urandom);
        cmd = {1'b0, j, 3'(a)};
        spi_byte(cmd, 8, b);
        spi_byte(8'(p), 8, b);
        spi_byte(8'(d), 8, b);
        if (a < NUM_PWM) begin
            mper[a]  = p;
            mduty[a] = d;
        end
    endtask

    task automatic spi_read(input int a);
        logic [7:0] b0, b1, b2, cmd;
        logic [3:0] j;
        j = 4'($urandom);
        cmd = {1'b1, j, 3'(a)};
        spi_byte(cmd, 8, b0);
        spi_byte(8'($urandom), 8, b1);
        spi_byte(8'($urandom), 8, b2);
        check($sformatf("rd%0d_cmd_byte", a), int'(b0), 0);
        check($sformatf("rd%0d_period", a), int'(b1), (a < NUM_PWM) ? mper[a] : 0);
        check($sformatf("rd%0d_duty", a), int'(b2), (a < NUM_PWM) ? mduty[a] : 0);
    endtask

    // Waveform model: high while ((t / SCALE) mod P) < D, measured from a rising edge.
    task automatic check_pwm(input int ch);
        int  p, d, bad, hi, exp_v;
        bit  prev, cur, found;
        logic [7:0] hib;
        p = mper[ch];
        d = mduty[ch];
        bad = 0;
        hi = 0;
        if (p == 0 || d == 0 || d >= p) begin
            exp_v = (p != 0 && d != 0) ? 1 : 0;
            for (int t = 0; t < 3 * (p + 1) * SCALE + 8; t++) begin
                @(negedge clk);
                if (io_out[1+ch] !== exp_v[0]) bad++;
                hib = io_out >> (NUM_PWM + 1);
                if (hib != 8'd0) hi++;
            end
            check($sformatf("pwm%0d_const_p%0d_d%0d_bad_samples", ch, p, d), bad, 0);
        end else begin
            found = 1'b0;
            prev = io_out[1+ch];
            for (int t = 0; t < 2 * p * SCALE + 8 && !found; t++) begin
                @(negedge clk);
                cur = io_out[1+ch];
                if (!prev && cur) found = 1'b1;
                prev = cur;
            end
            check($sformatf("pwm%0d_rise_seen", ch), int'(found), 1);
            if (found) begin
                for (int t = 0; t < 2 * p * SCALE; t++) begin
                    if (t > 0) @(negedge clk);
                    exp_v = (((t / SCALE) % p) < d) ? 1 : 0;
                    if (io_out[1+ch] !== exp_v[0]) bad++;
                    hib = io_out >> (NUM_PWM + 1);
                    if (hib != 8'd0) hi++;
                end
            end
            check($sformatf("pwm%0d_p%0d_d%0d_bad_samples", ch, p, d), bad, 0);
        end
        check($sformatf("pwm%0d_unused_out_nonzero", ch), hi, 0);
    endtask

    task automatic check_all();
        for (int c = 0; c < NUM_PWM; c++) check_pwm(c);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            mper[i]  = 0;
            mduty[i] = 0;
        end
    endtask

    initial begin
        logic [7:0] b;
        int a, p, d;
        clear_model();

        // Reset state
        wait_clks(3);
        check("io_out_in_reset", int'(io_out), 0);
        rst_n = 1'b1;
        wait_clks(2);
        check("io_out_after_reset", int'(io_out), 0);
        spi_read(0);

        // Full-on, then 3/8 duty with readback
        spi_write(0, 8, 8);
        check_all();
        spi_write(0, 8, 3);
        check_pwm(0);
        spi_read(0);

        // Short byte in CMD state is discarded, then a complete write of ch1
        spi_byte(8'h01, 5, b);
        spi_write(1, 4, 2);
        check_all();

        // Short byte while waiting for the duty byte leaves the transaction in place
        spi_byte(8'h02, 8, b);
        spi_byte(8'd6, 8, b);
        spi_byte(8'hFF, 3, b);
        spi_byte(8'd1, 8, b);
        mper[2]  = 6;
        mduty[2] = 1;
        check_all();
        spi_read(2);

        // Over-long byte: bits past the 8th are ignored
        spi_byte(8'h03, 8, b);
        spi_byte(8'd5, 11, b);
        spi_byte(8'd5, 8, b);
        mper[3]  = 5;
        mduty[3] = 5;
        spi_read(3);

        // Reset between bytes of a write aborts it with no commit
        spi_byte(8'h00, 8, b);
        spi_byte(8'd5, 8, b);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("io_out_async_reset", int'(io_out), 0);
        clear_model();
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(2);
        spi_read(0);
        check_pwm(0);

        // Out-of-range address
        spi_write(0, 3, 1);
        spi_write(7, 5, 2);
        check_all();
        spi_read(7);

        // Randomized writes with readback and waveform check
        for (int it = 0; it < 8; it++) begin
            a = int'($urandom_range(0, 7));
            p = int'($urandom_range(0, 12));
            d = int'($urandom_range(0, 14));
            spi_write(a, p, d);
            spi_read(a);
            if (a < NUM_PWM) check_pwm(a);
        end
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
